// File: rtl/jt12_ch_acc_pkg.sv
// Shared definitions for the channel accumulator: slot-group codes, the carrier
// lookup by algorithm and an output-width clamp.
package jt12_ch_acc_pkg;

  // Slot groups arrive in S1, S3, S2, S4 order within a frame
  localparam logic [1:0] GRP_S1 = 2'd0;
  localparam logic [1:0] GRP_S3 = 2'd1;
  localparam logic [1:0] GRP_S2 = 2'd2;
  localparam logic [1:0] GRP_S4 = 2'd3;

  function automatic logic is_carrier(input logic [2:0] alg, input logic [1:0] grp);
    case (grp)
      GRP_S4:  return 1'b1;
      GRP_S2:  return alg >= 3'd4;
      GRP_S3:  return alg >= 3'd5;
      default: return alg == 3'd7;
    endcase
  endfunction

  function automatic logic signed [20:0] clamp_w(input logic signed [20:0] v, input int w);
    logic signed [20:0] hi;
    logic signed [20:0] lo;
    hi = (21'sd1 <<< (w - 1)) - 21'sd1;
    lo = -hi - 21'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt12_sh.sv
// Fixed-length delay line; drop is the value pushed 'stages' enabled cycles ago.
module jt12_sh #(
  parameter int width  = 18,
  parameter int stages = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  logic [width-1:0] bits [stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) bits[i] <= '0;
    end else if (clk_en) begin
      bits[0] <= din;
      for (int i = 1; i < stages; i++) bits[i] <= bits[i-1];
    end
  end

  assign drop = bits[stages-1];

endmodule

// File: rtl/jt12_ch_acc.sv
// Sums carrier operator samples per channel from the slot-multiplexed stream,
// emits a panned sample per channel and a saturated L/R mix once per frame.
module jt12_ch_acc
  import jt12_ch_acc_pkg::*;
#(
  parameter int num_ch = 6,
  parameter int out_w  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  input  logic [13:0]      op_in,
  input  logic [2:0]       alg,
  input  logic [1:0]       rl,
  output logic [out_w-1:0] ch_l,
  output logic [out_w-1:0] ch_r,
  output logic [2:0]       ch_num,
  output logic             ch_valid,
  output logic [out_w-1:0] mix_l,
  output logic [out_w-1:0] mix_r,
  output logic             mix_valid
);

  // Slot position kept as (group, channel) so no divide is needed
  logic [2:0]  ch_cnt, ch, ch_nx;
  logic [1:0]  grp_cnt, grp, grp_nx;
  logic        last_ch;

  logic signed [17:0] term, acc_drop, sum;
  logic        [17:0] sh_din, sh_drop;
  logic signed [20:0] pan_l, pan_r;
  logic signed [20:0] mix_acc_l, mix_acc_r, mix_sum_l, mix_sum_r;
  logic signed [20:0] ch_l_c, ch_r_c, mix_l_c, mix_r_c;

  always_comb begin
    ch      = zero ? 3'd0 : ch_cnt;
    grp     = zero ? GRP_S1 : grp_cnt;
    last_ch = (ch == 3'(num_ch - 1));
    ch_nx   = last_ch ? 3'd0 : ch + 3'd1;
    grp_nx  = last_ch ? grp + 2'd1 : grp;
  end

  always_comb begin
    term      = is_carrier(alg, grp) ? {{4{op_in[13]}}, op_in} : 18'sd0;
    acc_drop  = $signed(sh_drop);
    sum       = acc_drop + term;
    sh_din    = (grp == GRP_S1) ? term : sum;
    pan_l     = rl[1] ? {{3{sum[17]}}, sum} : 21'sd0;
    pan_r     = rl[0] ? {{3{sum[17]}}, sum} : 21'sd0;
    // Channel 0 starts a fresh mix, so a resync never carries stale sums
    mix_sum_l = ((ch == 3'd0) ? 21'sd0 : mix_acc_l) + pan_l;
    mix_sum_r = ((ch == 3'd0) ? 21'sd0 : mix_acc_r) + pan_r;
    ch_l_c    = clamp_w(pan_l, out_w);
    ch_r_c    = clamp_w(pan_r, out_w);
    mix_l_c   = clamp_w(mix_sum_l, out_w);
    mix_r_c   = clamp_w(mix_sum_r, out_w);
  end

  jt12_sh #(.width(18), .stages(num_ch)) u_acc_sh (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .din    (sh_din),
    .drop   (sh_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt    <= '0;
      grp_cnt   <= GRP_S1;
      ch_l      <= '0;
      ch_r      <= '0;
      ch_num    <= '0;
      ch_valid  <= 1'b0;
      mix_l     <= '0;
      mix_r     <= '0;
      mix_valid <= 1'b0;
      mix_acc_l <= '0;
      mix_acc_r <= '0;
    end else if (clk_en) begin
      ch_cnt    <= ch_nx;
      grp_cnt   <= grp_nx;
      ch_valid  <= 1'b0;
      mix_valid <= 1'b0;
      if (grp == GRP_S4) begin
        ch_l      <= ch_l_c[out_w-1:0];
        ch_r      <= ch_r_c[out_w-1:0];
        ch_num    <= ch;
        ch_valid  <= 1'b1;
        mix_acc_l <= mix_sum_l;
        mix_acc_r <= mix_sum_r;
        if (last_ch) begin
          mix_l     <= mix_l_c[out_w-1:0];
          mix_r     <= mix_r_c[out_w-1:0];
          mix_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_ch_acc.sv
// Directed and randomized frames for jt12_ch_acc checked against a per-channel
// sum model; clk_en gaps and resets are interleaved with the frames.
module tb_jt12_ch_acc;

  localparam int NCH = 6;
  localparam int W   = 35;

  logic        clk = 1'b0;
  logic        rst, clk_en, zero;
  logic [13:0] op_in;
  logic [2:0]  alg;
  logic [1:0]  rl;
  logic [15:0] ch_l, ch_r, mix_l, mix_r;
  logic [2:0]  ch_num;
  logic        ch_valid, mix_valid;

  jt12_ch_acc #(.num_ch(NCH), .out_w(16)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .op_in(op_in),
    .alg(alg), .rl(rl), .ch_l(ch_l), .ch_r(ch_r), .ch_num(ch_num),
    .ch_valid(ch_valid), .mix_l(mix_l), .mix_r(mix_r), .mix_valid(mix_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  int           m_slot;
  int           m_sum [NCH];
  int           m_mix_l, m_mix_r;
  logic [15:0]  e_ch_l, e_ch_r, e_mix_l, e_mix_r;
  logic [2:0]   e_num;
  bit           e_valid, e_mix_valid;

  function automatic bit carrier(input int a, input int g);
    int ncar;
    int rank;
    ncar = (a < 4) ? 1 : (a == 4) ? 2 : (a < 7) ? 3 : 4;
    // carriers are added in the order S4, S2, S3, S1 as the algorithm number grows
    case (g)
      3:       rank = 0;
      2:       rank = 1;
      1:       rank = 2;
      default: rank = 3;
    endcase
    return rank < ncar;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    for (int i = 0; i < NCH; i++) m_sum[i] = 0;
    m_mix_l = 0; m_mix_r = 0;
    e_ch_l = '0; e_ch_r = '0; e_num = '0; e_valid = 0;
    e_mix_l = '0; e_mix_r = '0; e_mix_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic z, input logic [13:0] op, input logic [2:0] a,
                            input logic [1:0] r);
    int s, g, c, t, fin, pl, pr;
    s = z ? 0 : m_slot;
    g = s / NCH;
    c = s % NCH;
    t = carrier(int'(a), g) ? int'($signed(op)) : 0;
    e_valid = 0;
    e_mix_valid = 0;
    if (g == 0) m_sum[c] = t;
    else if (g < 3) m_sum[c] = m_sum[c] + t;
    else begin
      fin = m_sum[c] + t;
      pl = r[1] ? fin : 0;
      pr = r[0] ? fin : 0;
      exp_q.push_back({3'(c), 16'(sat16(pl)), 16'(sat16(pr))});
      e_valid = 1;
      if (c == 0) begin m_mix_l = pl; m_mix_r = pr; end
      else begin m_mix_l += pl; m_mix_r += pr; end
      if (c == NCH - 1) begin
        e_mix_l = 16'(sat16(m_mix_l));
        e_mix_r = 16'(sat16(m_mix_r));
        e_mix_valid = 1;
      end
    end
    m_slot = (s + 1) % (4 * NCH);
  endtask

  task automatic check_all(input bit pop);
    logic [W-1:0] w;
    if (pop && e_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $error("FAIL exp_q_empty observed=0 expected=1");
      end else begin
        w = exp_q.pop_front();
        e_num = w[34:32]; e_ch_l = w[31:16]; e_ch_r = w[15:0];
      end
    end
    check("ch_valid",  32'(ch_valid),  32'(e_valid));
    check("ch_num",    32'(ch_num),    32'(e_num));
    check("ch_l",      32'(ch_l),      32'(e_ch_l));
    check("ch_r",      32'(ch_r),      32'(e_ch_r));
    check("mix_valid", 32'(mix_valid), 32'(e_mix_valid));
    check("mix_l",     32'(mix_l),     32'(e_mix_l));
    check("mix_r",     32'(mix_r),     32'(e_mix_r));
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst = 1'b1; clk_en = en; zero = 1'($urandom_range(0, 1));
    op_in = 14'($urandom);
    @(posedge clk); #1;
    model_reset();
    check_all(0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_slot(input logic z, input logic [13:0] op, input logic [2:0] a,
                         input logic [1:0] r);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        @(negedge clk);
        clk_en = 1'b0; zero = 1'($urandom_range(0, 1)); op_in = 14'($urandom);
        alg = 3'($urandom); rl = 2'($urandom);
        @(posedge clk); #1;
        check_all(0);
      end
    end
    @(negedge clk);
    clk_en = 1'b1; zero = z; op_in = op; alg = a; rl = r;
    @(posedge clk); #1;
    model_step(z, op, a, r);
    check_all(1);
  endtask

  // Stimulus value for slot i of a frame in a given mode
  task automatic gen(input int mode, input int i, output logic [13:0] op,
                     output logic [2:0] a, output logic [1:0] r);
    int g, c, v;
    g = (i / NCH) % 4;
    c = i % NCH;
    v = int'($urandom_range(0, 16383));
    a = 3'($urandom); r = 2'($urandom);
    case (mode)
      1: begin a = 3'd7; v = 100; r = 2'b11; end
      2: begin
        r = 2'b11;
        if (c % 2 == 0) begin a = 3'd0; v = (g == 3) ? -5 : 1000; end
        else begin
          a = 3'd4;
          if (g == 2) v = 300;
          else if (g == 3) v = 200;
        end
      end
      3: begin a = 3'd7; v = -8192; r = 2'b11; end
      4: begin a = 3'd7; v = 8000; r = 2'b01; end
      default: ;
    endcase
    op = v[13:0];
  endtask

  task automatic run_slots(input int mode, input int n, input bit zero_first);
    logic [13:0] op;
    logic [2:0]  a;
    logic [1:0]  r;
    for (int i = 0; i < n; i++) begin
      gen(mode, i, op, a, r);
      do_slot(zero_first && (i == 0), op, a, r);
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; zero = 1'b0; op_in = '0; alg = '0; rl = '0;
    model_reset();
    do_reset(1'b1);
    run_slots(0, 24, 1);
    run_slots(0, 13, 1);
    do_reset(1'b0);
    run_slots(0, 5, 0);
    run_slots(1, 24, 1);
    run_slots(2, 24, 1);
    run_slots(3, 24, 1);
    run_slots(4, 24, 1);
    run_slots(1, 10, 1);
    run_slots(1, 24, 1);
    run_slots(1, 24, 0);
    repeat (6) run_slots(0, 24, 1);
    run_slots(0, 24, 0);
    do_reset(1'b1);
    run_slots(3, 24, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
